memory_handler: RTL and testbench

Sequential data-memory port between the execute stage and the data bus. It accepts one load or store at a time from the core, runs a request/acknowledge transaction on the bus, and stalls the core until the transaction finishes. For loads it delivers `memory_value` to the writeback mux, with byte loads already shifted into bits [7:0]. For stores it drives the register operand onto the bus with byte enables.

---
 rtl/memory_pkg.sv | 13 +
 rtl/byte_lane.sv | 31 +++
 rtl/memory_handler.sv | 145 ++++++++++++++
 tb/tb_memory_handler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and constants for the data-memory port.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [3:0] BYTE_SEL_BASE          = 4'b0001;
    localparam int         TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/byte_lane.sv
// Byte-lane steering: bus byte enables, replicated store data and load-byte extraction.
module byte_lane
    import memory_pkg::*;
(
    input  logic        byte_access_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_value_o
);

    logic [7:0] load_byte;

    always_comb begin
        load_byte = rdata_i[7:0];
        case (lane_i)
            2'd0: load_byte = rdata_i[7:0];
            2'd1: load_byte = rdata_i[15:8];
            2'd2: load_byte = rdata_i[23:16];
            2'd3: load_byte = rdata_i[31:24];
            default: load_byte = rdata_i[7:0];
        endcase
    end

    assign sel_o        = byte_access_i ? (BYTE_SEL_BASE << lane_i) : 4'hF;
    assign wdata_o      = byte_access_i ? {4{store_data_i[7:0]}} : store_data_i;
    assign load_value_o = byte_access_i ? {24'b0, load_byte} : rdata_i;

endmodule

// File: rtl/memory_handler.sv
// Single-outstanding load/store port with req/ack bus handshake and core stall.
// Optional wait-state timeout with sticky bus_error: define MEMORY_HANDLER_TIMEOUT_EN.
module memory_handler
    import memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        byte_access,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] memory_value,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef MEMORY_HANDLER_TIMEOUT_EN
    ,
    output logic        bus_error
`endif
);

    // state | meaning
    // IDLE  | no access in flight; a request is latched and stalls the core
    // WAIT  | bus_req held with stable bus fields until bus_ack (or timeout)
    // DONE  | one-cycle completion; stall drops so the core advances once

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("memory_handler: TIMEOUT_CYCLES must be in 1..256");
    end

    mem_state_t  state_q, state_d;
    logic        we_q;
    logic        byte_q;
    logic [1:0]  lane_q;
    logic [29:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] mem_value_q;

    logic        req;
    logic        start;
    logic        in_wait;
    logic        ack_take;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] load_value;

    assign req      = mem_read | mem_write;
    assign start    = (state_q == IDLE) & req;
    assign in_wait  = (state_q == WAIT);
    assign ack_take = in_wait & bus_ack;

`ifdef MEMORY_HANDLER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_q;
    logic       error_q;
    logic       timeout_hit;

    // ack in the same cycle as the limit takes priority over the abort
    assign timeout_hit = in_wait & ~bus_ack & (wait_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            if (start) begin
                wait_cnt_q <= 8'd0;
            end else if (in_wait) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus_error = error_q;
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = WAIT;
            WAIT:    if (bus_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= 2'd0;
            addr_q      <= 30'd0;
            sdata_q     <= 32'd0;
            mem_value_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (start) begin
                we_q    <= mem_write;
                byte_q  <= byte_access;
                lane_q  <= address[1:0];
                addr_q  <= address[31:2];
                sdata_q <= store_data;
            end
            if (ack_take && !we_q) begin
                mem_value_q <= load_value;
            end
        end
    end

    byte_lane u_byte_lane (
        .byte_access_i (byte_q),
        .lane_i        (lane_q),
        .store_data_i  (sdata_q),
        .rdata_i       (bus_rdata),
        .sel_o         (lane_sel),
        .wdata_o       (lane_wdata),
        .load_value_o  (load_value)
    );

    // bus fields come only from latched state, so they cannot move during WAIT
    assign bus_req      = in_wait;
    assign bus_we       = in_wait & we_q;
    assign bus_addr     = in_wait ? {addr_q, 2'b00} : 32'd0;
    assign bus_wdata    = in_wait ? lane_wdata : 32'd0;
    assign bus_sel      = in_wait ? lane_sel : 4'd0;
    assign stall        = start | in_wait;
    assign memory_value = mem_value_q;

endmodule

// File: tb/tb_memory_handler.sv
// Directed self-checking bench for memory_handler; timeout steps build only with MEMORY_HANDLER_TIMEOUT_EN.
module tb_memory_handler;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, byte_access;
   logic [31:0] address, store_data;
   logic [31:0] memory_value;
   logic        stall, bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_sel;
`ifdef MEMORY_HANDLER_TIMEOUT_EN
   logic        bus_error;
   localparam int TB_TIMEOUT_CYCLES = 4;
`else
   localparam int TB_TIMEOUT_CYCLES = 255;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   memory_handler #(.TIMEOUT_CYCLES(TB_TIMEOUT_CYCLES)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .byte_access  (byte_access),
      .address      (address),
      .store_data   (store_data),
      .memory_value (memory_value),
      .stall        (stall),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_sel      (bus_sel),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata)
`ifdef MEMORY_HANDLER_TIMEOUT_EN
      ,
      .bus_error    (bus_error)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; byte_access = 1'b0;
      address = 32'd0; store_data = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
      next_cyc();
      next_cyc();
      chk("rst_mv",    memory_value, 32'd0);
      chk("rst_req",   bus_req,      32'd0);
      chk("rst_we",    bus_we,       32'd0);
      chk("rst_addr",  bus_addr,     32'd0);
      chk("rst_wdata", bus_wdata,    32'd0);
      chk("rst_sel",   bus_sel,      32'd0);
      chk("rst_stall", stall,        32'd0);
`ifdef MEMORY_HANDLER_TIMEOUT_EN
      chk("rst_err",   bus_error,    32'd0);
`endif
      rst = 1'b0;
      next_cyc();

      // word load 0x100, ack in cycle 1
      mem_read = 1'b1; address = 32'h100; byte_access = 1'b0;
      sample();
      chk("t1_c0_stall", stall,   32'd1);
      chk("t1_c0_req",   bus_req, 32'd0);
      next_cyc();
      mem_read = 1'b0; address = 32'hFFFF_FFFF; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
      sample();
      chk("t1_c1_req",   bus_req,  32'd1);
      chk("t1_c1_addr",  bus_addr, 32'h100);
      chk("t1_c1_sel",   bus_sel,  32'hF);
      chk("t1_c1_we",    bus_we,   32'd0);
      chk("t1_c1_stall", stall,    32'd1);
      next_cyc();
      bus_ack = 1'b0; bus_rdata = 32'd0;
      sample();
      chk("t1_done_stall", stall,        32'd0);
      chk("t1_done_req",   bus_req,      32'd0);
      chk("t1_done_mv",    memory_value, 32'hDEADBEEF);
      next_cyc();
      sample();
      chk("t1_idle_stall", stall,   32'd0);
      chk("t1_idle_req",   bus_req, 32'd0);
      next_cyc();

      // byte load 0x103 -> lane 3
      mem_read = 1'b1; address = 32'h103; byte_access = 1'b1;
      next_cyc();
      mem_read = 1'b0; byte_access = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hAABBCCDD;
      sample();
      chk("t2_addr", bus_addr, 32'h100);
      chk("t2_sel",  bus_sel,  32'h8);
      next_cyc();
      bus_ack = 1'b0;
      sample();
      chk("t2_mv", memory_value, 32'h0000_00AA);
      next_cyc();
      next_cyc();

      // byte load 0x101 -> lane 1
      mem_read = 1'b1; address = 32'h101; byte_access = 1'b1;
      next_cyc();
      mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h11223344;
      sample();
      chk("t2b_sel", bus_sel, 32'h2);
      next_cyc();
      bus_ack = 1'b0;
      sample();
      chk("t2b_mv", memory_value, 32'h0000_0033);
      next_cyc();
      next_cyc();

      // byte store 0x202 with 3 wait states; core inputs scrambled after issue
      mem_write = 1'b1; address = 32'h202; byte_access = 1'b1; store_data = 32'h12345678;
      sample();
      chk("t3_c0_stall", stall, 32'd1);
      next_cyc();
      mem_write = 1'b0; address = 32'hFFFF_FFFF; byte_access = 1'b0; store_data = 32'd0;
      for (int i = 0; i < 4; i++) begin
         bus_ack = (i == 3); bus_rdata = 32'h5555_5555;
         sample();
         chk("t3_req",   bus_req,   32'd1);
         chk("t3_we",    bus_we,    32'd1);
         chk("t3_addr",  bus_addr,  32'h200);
         chk("t3_sel",   bus_sel,   32'h4);
         chk("t3_wdata", bus_wdata, 32'h78787878);
         chk("t3_stall", stall,     32'd1);
         next_cyc();
      end
      bus_ack = 1'b0;
      sample();
      chk("t3_done_mv",    memory_value, 32'h0000_0033);
      chk("t3_done_stall", stall,        32'd0);
      chk("t3_done_req",   bus_req,      32'd0);
      next_cyc();
      next_cyc();

      // read and write together: write wins
      mem_read = 1'b1; mem_write = 1'b1; address = 32'h300; byte_access = 1'b0;
      store_data = 32'hCAFEF00D;
      next_cyc();
      mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
      sample();
      chk("t4_we",    bus_we,    32'd1);
      chk("t4_wdata", bus_wdata, 32'hCAFEF00D);
      chk("t4_sel",   bus_sel,   32'hF);
      chk("t4_addr",  bus_addr,  32'h300);
      next_cyc();
      bus_ack = 1'b0;
      sample();
      chk("t4_mv", memory_value, 32'h0000_0033);
      next_cyc();
      next_cyc();

      // ack while idle is ignored
      bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
      sample();
      chk("t5_req",   bus_req, 32'd0);
      chk("t5_stall", stall,   32'd0);
      next_cyc();
      bus_ack = 1'b0;
      sample();
      chk("t5_mv", memory_value, 32'h0000_0033);
      next_cyc();

      // reset during WAIT
      mem_read = 1'b1; address = 32'h104; byte_access = 1'b0;
      next_cyc();
      mem_read = 1'b0;
      sample();
      chk("t6_wait_req", bus_req, 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_rst_req",   bus_req,      32'd0);
      chk("t6_rst_stall", stall,        32'd0);
      chk("t6_rst_mv",    memory_value, 32'd0);
      next_cyc();
      rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
      sample();
      chk("t6_ack_req",   bus_req, 32'd0);
      chk("t6_ack_stall", stall,   32'd0);
      next_cyc();
      bus_ack = 1'b0;
      sample();
      chk("t6_post_mv",  memory_value, 32'd0);
      chk("t6_post_req", bus_req,      32'd0);
      next_cyc();

`ifdef MEMORY_HANDLER_TIMEOUT_EN
      mem_read = 1'b1; address = 32'h400; byte_access = 1'b0;
      next_cyc();
      mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BADCAFE;
      next_cyc();
      bus_ack = 1'b0;
      next_cyc();
      mem_read = 1'b1; address = 32'h404;
      next_cyc();
      mem_read = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("t7_wait_req", bus_req,   32'd1);
         chk("t7_wait_err", bus_error, 32'd0);
         next_cyc();
      end
      sample();
      chk("t7_done_req",   bus_req,      32'd0);
      chk("t7_done_err",   bus_error,    32'd1);
      chk("t7_done_mv",    memory_value, 32'h0BADCAFE);
      chk("t7_done_stall", stall,        32'd0);
      next_cyc();
      next_cyc();
      sample();
      chk("t7_sticky_err", bus_error, 32'd1);
      next_cyc();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
